// File: rtl/decrementor_nb.sv
// Registered N-bit decrement unit with programmable step and selectable
// underflow handling (wrap, saturate, reload, hold), for loop/delay counting.
module decrementor_nb #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  out,
  output logic              cout,
  output logic              uflow,
  output logic              zero
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_RELOAD = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   diff;
  logic             borrow;

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] reload_d;
  logic             cout_d;
  logic             uflow_d;

  assign mode_sel = mode_e'(mode);

  // One guard bit above the count; the top bit of the difference is the borrow.
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign diff     = {1'b0, out} - step_ext;
  assign borrow   = diff[WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    out_d    = out;
    reload_d = reload_q;
    cout_d   = cout;
    uflow_d  = uflow;

    if (load) begin
      out_d    = load_val;
      reload_d = load_val;
      cout_d   = 1'b0;
      uflow_d  = 1'b0;
    end else if (mode_sel != MODE_HOLD) begin
      if (!en) begin
        cout_d = 1'b0;
      end else if (!borrow) begin
        out_d  = diff[WIDTH-1:0];
        cout_d = 1'b0;
      end else begin
        cout_d  = 1'b1;
        uflow_d = 1'b1;
        case (mode_sel)
          MODE_WRAP:   out_d = diff[WIDTH-1:0];
          MODE_SAT:    out_d = '0;
          MODE_RELOAD: out_d = reload_q;
          default:     out_d = out;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      reload_q <= '0;
      cout     <= 1'b0;
      uflow    <= 1'b0;
    end else begin
      out      <= out_d;
      reload_q <= reload_d;
      cout     <= cout_d;
      uflow    <= uflow_d;
    end
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_decrementor_nb.sv
// Self-checking bench for decrementor_nb: an arithmetic reference model
// checked every cycle, plus directed literal expectations at both widths.
module tb_decrementor_nb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        load8 = 1'b0, en8 = 1'b0;
  logic [7:0]  load_val8 = '0;
  logic [3:0]  step8 = '0;
  logic [1:0]  mode8 = '0;
  logic [7:0]  out8;
  logic        cout8, uflow8, zero8;

  logic        load16 = 1'b0, en16 = 1'b0;
  logic [15:0] load_val16 = '0;
  logic [7:0]  step16 = '0;
  logic [1:0]  mode16 = '0;
  logic [15:0] out16;
  logic        cout16, uflow16, zero16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  decrementor_nb #(.WIDTH(8), .STEP_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .load_val(load_val8), .en(en8),
    .step(step8), .mode(mode8), .out(out8), .cout(cout8), .uflow(uflow8),
    .zero(zero8)
  );

  decrementor_nb #(.WIDTH(16), .STEP_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .load(load16), .load_val(load_val16), .en(en16),
    .step(step16), .mode(mode16), .out(out16), .cout(cout16), .uflow(uflow16),
    .zero(zero16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: plain integer arithmetic on the counter value.
  typedef struct {
    longint cnt;
    longint rel;
    bit     cout;
    bit     uflow;
  } mstate_t;

  function automatic mstate_t mstep(int w, mstate_t s, bit ld, longint lv,
                                    bit e, longint st, bit [1:0] md);
    mstate_t n = s;
    if (ld) begin
      n.cnt = lv; n.rel = lv; n.cout = 1'b0; n.uflow = 1'b0;
    end else if (md == 2'd3) begin
      n = s;
    end else if (!e) begin
      n.cout = 1'b0;
    end else if (s.cnt >= st) begin
      n.cnt = s.cnt - st; n.cout = 1'b0;
    end else begin
      n.cout = 1'b1; n.uflow = 1'b1;
      case (md)
        2'd0:    n.cnt = s.cnt - st + (64'sd1 <<< w);
        2'd1:    n.cnt = 0;
        default: n.cnt = s.rel;
      endcase
    end
    return n;
  endfunction

  mstate_t m8  = '{0, 0, 1'b0, 1'b0};
  mstate_t m16 = '{0, 0, 1'b0, 1'b0};

  // Compare process: model advances on each edge, DUT sampled 1 ns later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8  = '{0, 0, 1'b0, 1'b0};
      m16 = '{0, 0, 1'b0, 1'b0};
    end else begin
      m8  = mstep(8,  m8,  load8,  longint'(load_val8),  en8,  longint'(step8),  mode8);
      m16 = mstep(16, m16, load16, longint'(load_val16), en16, longint'(step16), mode16);
      #1;
      if (rst_n) begin
        check("model out8",    64'(out8),    64'(m8.cnt));
        check("model cout8",   64'(cout8),   64'(m8.cout));
        check("model uflow8",  64'(uflow8),  64'(m8.uflow));
        check("model zero8",   64'(zero8),   64'(m8.cnt == 0));
        check("model out16",   64'(out16),   64'(m16.cnt));
        check("model cout16",  64'(cout16),  64'(m16.cout));
        check("model uflow16", 64'(uflow16), 64'(m16.uflow));
        check("model zero16",  64'(zero16),  64'(m16.cnt == 0));
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge, after the
  // rising edge that sampled these inputs.
  task automatic drive8(input logic ld, input logic [7:0] lv, input logic e,
                        input logic [3:0] st, input logic [1:0] md);
    load8 = ld; load_val8 = lv; en8 = e; step8 = st; mode8 = md;
    @(negedge clk);
  endtask

  task automatic drive16(input logic ld, input logic [15:0] lv, input logic e,
                         input logic [7:0] st, input logic [1:0] md);
    load16 = ld; load_val16 = lv; en16 = e; step16 = st; mode16 = md;
    @(negedge clk);
  endtask

  logic [7:0] exp_out [5];
  logic       exp_c   [5];

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and load
    drive8(1'b1, 8'h05, 1'b0, 4'd0, 2'b00);
    check("load out", 64'(out8), 64'h05);
    check("load zero", 64'(zero8), 64'd0);
    drive8(1'b0, 8'h00, 1'b1, 4'd1, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out", 64'(out8), 64'h00);
    check("async rst cout", 64'(cout8), 64'd0);
    check("async rst uflow", 64'(uflow8), 64'd0);
    check("async rst zero", 64'(zero8), 64'd1);
    rst_n = 1'b1;
    en8 = 1'b0;
    @(negedge clk);

    // Step-1 countdown, wrap
    drive8(1'b1, 8'h03, 1'b0, 4'd0, 2'b00);
    exp_out = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    exp_c   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 4'd1, 2'b00);
      check("wrap out", 64'(out8), 64'(exp_out[i]));
      check("wrap cout", 64'(cout8), 64'(exp_c[i]));
    end
    check("wrap uflow sticky", 64'(uflow8), 64'd1);

    // Multi-step saturate
    drive8(1'b1, 8'h0A, 1'b0, 4'd0, 2'b01);
    check("load clears uflow", 64'(uflow8), 64'd0);
    exp_out = '{8'h06, 8'h02, 8'h00, 8'h00, 8'h00};
    exp_c   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 4'd4, 2'b01);
      check("sat out", 64'(out8), 64'(exp_out[i]));
      check("sat cout", 64'(cout8), 64'(exp_c[i]));
    end

    // Reload
    drive8(1'b1, 8'h07, 1'b0, 4'd0, 2'b10);
    exp_out = '{8'h04, 8'h01, 8'h07, 8'h04, 8'h01};
    exp_c   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 4'd3, 2'b10);
      check("reload out", 64'(out8), 64'(exp_out[i]));
      check("reload cout", 64'(cout8), 64'(exp_c[i]));
    end
    check("reload uflow sticky", 64'(uflow8), 64'd1);

    // Priority: load beats en
    drive8(1'b1, 8'h20, 1'b1, 4'd5, 2'b00);
    check("load over en", 64'(out8), 64'h20);
    drive8(1'b1, 8'h02, 1'b0, 4'd0, 2'b00);
    drive8(1'b0, 8'h00, 1'b1, 4'd5, 2'b00);
    check("wrap 02-5 out", 64'(out8), 64'hFD);
    check("wrap 02-5 cout", 64'(cout8), 64'd1);
    // Hold freezes everything including a high cout
    for (int i = 0; i < 2; i++) begin
      drive8(1'b0, 8'h00, 1'b1, 4'd1, 2'b11);
      check("hold out", 64'(out8), 64'hFD);
      check("hold cout", 64'(cout8), 64'd1);
    end
    drive8(1'b0, 8'h00, 1'b1, 4'd0, 2'b00);
    check("step0 out", 64'(out8), 64'hFD);
    check("step0 cout", 64'(cout8), 64'd0);
    // Unknown data inputs are ignored while idle
    drive8(1'b0, 8'hxx, 1'b0, 4'hx, 2'b01);
    check("idle x out", 64'(out8), 64'hFD);
    check("idle x uflow", 64'(uflow8), 64'd1);
    // Mode switch to saturate takes effect on the same edge
    drive8(1'b0, 8'h00, 1'b1, 4'hF, 2'b01);
    check("mode switch out", 64'(out8), 64'hEE);
    drive8(1'b0, 8'h00, 1'b0, 4'd0, 2'b00);

    // Parametric width
    drive16(1'b1, 16'h0100, 1'b0, 8'h00, 2'b00);
    drive16(1'b0, 16'h0000, 1'b1, 8'hFF, 2'b00);
    check("w16 out1", 64'(out16), 64'h0001);
    check("w16 cout1", 64'(cout16), 64'd0);
    drive16(1'b0, 16'h0000, 1'b1, 8'hFF, 2'b00);
    check("w16 out2", 64'(out16), 64'hFF02);
    check("w16 cout2", 64'(cout16), 64'd1);
    drive16(1'b0, 16'h0000, 1'b0, 8'h00, 2'b00);
    check("w16 cout drop", 64'(cout16), 64'd0);
    check("w16 uflow", 64'(uflow16), 64'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decrementor_nb.md
Name: decrementor_nb

Overview:
- Registered, parametrised N-bit decrement unit; successor to the 4-bit combinational decrementor in the ALU datapath.
- Holds a count register that decrements by a programmable step on each enabled cycle.
- Supports selectable underflow handling: wrap, saturate, auto-reload or hold.
- Reports a borrow pulse (cout), a sticky underflow flag and a zero flag, for use as a loop or delay counter next to the ALU.

Parameters:
WIDTH, 8, width of count register, load value and out
STEP_W, 4, width of the step input; must satisfy 1 <= STEP_W <= WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  load load_val into count and reload registers this cycle
load_val  input  WIDTH  value captured on load
en  input  1  decrement enable
step  input  STEP_W  decrement amount, unsigned, zero-extended to WIDTH
mode  input  2  00 wrap, 01 saturate, 10 reload, 11 hold
out  output  WIDTH  current count (registered)
cout  output  1  registered borrow pulse: high for one cycle after a decrement that underflowed
uflow  output  1  sticky underflow flag; cleared only by load or reset
zero  output  1  combinational, equals (out == 0)

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - out, reload register, cout and uflow go to 0; zero therefore reads 1.
  - Release is synchronous to the next rising clk.
  - Reset asserted mid-operation discards all state immediately.
- Arithmetic:
  - diff = {1'b0, out} - {1'b0, zext(step)}, computed at WIDTH+1 bits.
  - borrow = diff[WIDTH], which equals (out < step).
  - Unsigned only; no signed interpretation.
- Priority per rising edge: load > hold mode > en > idle.
- load = 1:
  - out <= load_val and reload <= load_val.
  - cout <= 0 and uflow <= 0.
  - en and mode are ignored this cycle.
- mode = 11 (hold), no load: out, cout and uflow keep their values; en is ignored.
- en = 0, no load, mode != 11: out and uflow hold; cout <= 0.
- en = 1, no load, borrow = 0: out <= diff[WIDTH-1:0]; cout <= 0. This applies in every mode except hold.
- en = 1, no load, borrow = 1: cout <= 1 and uflow <= 1, plus:
  - mode 00 wrap: out <= diff[WIDTH-1:0] (modulo 2^WIDTH).
  - mode 01 saturate: out <= 0.
  - mode 10 reload: out <= reload register value (not reduced by step).
- step = 0 with en = 1: out unchanged, borrow = 0, cout <= 0.
- Reaching exactly 0 (out == step) is not an underflow: out <= 0, cout <= 0, zero goes high.
- Successive underflows give a cout pulse on each offending cycle; cout is never stretched.
- Mode changes take effect on the same edge they are sampled; no internal state depends on the previous mode.
- Latency: one cycle from en/load sampling to out, cout and uflow; zero follows out combinationally.
- No X propagation from step or load_val when en = 0 and load = 0.

Test Plan:
- Reset and load (WIDTH=8): assert rst_n = 0 asynchronously mid-cycle -> out = 0x00, cout = 0, uflow = 0, zero = 1 immediately. Then load = 1, load_val = 0x05 -> out = 0x05, zero = 0 next cycle.
- Step-1 countdown, wrap: load 0x03, mode 00, en = 1, step = 1 for 5 cycles -> out = 02, 01, 00, FF, FE; cout high only in the cycle out = FF; uflow = 1 from then on; zero high only while out = 00.
- Multi-step saturate: load 0x0A, mode 01, step = 4 -> out = 06, 02, 00; cout = 1 on the 02->00 transition only; further en cycles hold 00 with cout = 1 each cycle.
- Reload: load 0x07, mode 10, step = 3 -> out = 04, 01, 07, 04; cout pulses exactly on the 01->07 edge; uflow stays 1 until the next load.
- Priority: load = 1 and en = 1 together with load_val = 0x20, step = 5 -> out = 0x20, not 0x1B. Mode 11 with en = 1 -> out frozen and cout holds its value. step = 0 -> no change, cout = 0.
- Parametric: WIDTH = 16, STEP_W = 8, load 0x0100, step = 0xFF, mode 00 -> out = 0x0001, then 0xFF02 with cout = 1.
